fetch: RTL

// - Instruction-fetch stage: producer of the {pc, insn} pair consumed by the decode stage.
// - Drives a valid/ready request channel to instruction memory, accepts in-order responses,
//   and buffers them in a small queue so decode stalls never drop or duplicate instructions.
// - Handles control-flow redirects: flushes the queue and discards stale in-flight responses.
//

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_AWIDTH = 32;
  localparam int FETCH_DWIDTH = 32;

  localparam logic [FETCH_AWIDTH-1:0] IMEM_BASE_ADDR = 32'h0000_1000;
  localparam logic [FETCH_DWIDTH-1:0] INSN_NOP       = 32'h0000_0013;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [FETCH_AWIDTH-1:0] pc;
    logic [FETCH_DWIDTH-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of fetch entries between instruction memory and decode.
// Pointers wrap explicitly at DEPTH so non-power-of-2 depths work.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: issues word-aligned requests under a credit limit,
// queues in-order responses, and discards stale responses after a redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter int DWIDTH = FETCH_DWIDTH,
  parameter int AWIDTH = FETCH_AWIDTH,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] rsp_pc;
  logic [AWIDTH-1:0] pc_hold;
  logic [AWIDTH-1:0] target_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              credit_ok;
  logic              accept;
  logic              rsp_live;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  // Outstanding requests plus buffered entries never exceed the queue depth,
  // so every response always has a slot waiting for it.
  assign credit_ok        = ({1'b0, inflight} + {1'b0, count}) < DEPTH_W;
  assign imem_req_valid_o = rst && !redirect_i && credit_ok;
  assign imem_req_addr_o  = fetch_pc;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  // Responses with nothing outstanding are ignored rather than corrupting counters.
  assign rsp_live  = imem_rsp_valid_i && (inflight != '0);
  assign push      = rsp_live && (drop == '0) && !redirect_i;
  assign pop       = valid_o && !stall_i && !redirect_i;
  assign target_pc = {redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign push_data = '{pc: rsp_pc, insn: imem_rsp_data_i};

  assign valid_o = !empty;
  assign pc_o    = empty ? pc_hold : head.pc;
  assign insn_o  = empty ? INSN_NOP : head.insn;

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Fetch/response address tracking, outstanding-request and stale-drop counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= AWIDTH'(IMEM_BASE_ADDR);
      rsp_pc   <= AWIDTH'(IMEM_BASE_ADDR);
      pc_hold  <= AWIDTH'(IMEM_BASE_ADDR);
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(rsp_live);
      if (redirect_i) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        // Everything still outstanding belongs to the old path.
        drop     <= inflight - CW'(rsp_live);
      end else begin
        if (accept)                  fetch_pc <= fetch_pc + AWIDTH'(4);
        if (push)                    rsp_pc   <= rsp_pc + AWIDTH'(4);
        if (rsp_live && drop != '0)  drop     <= drop - 1'b1;
      end
      if (!empty) pc_hold <= head.pc;
    end
  end

  a_rsp_without_request: assert property (
    @(posedge clk) disable iff (!rst) !(imem_rsp_valid_i && inflight == '0));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule
